// File: rtl/n64_response_receiver_pkg.sv
// n64_pkg: shared constants, response field map and receiver state encoding.
`default_nettype none
`timescale 1ns/1ps

package n64_pkg;

  localparam int RESP_BITS = 32;

  // Bit positions inside the 32-bit response word (MSB = first bit on the wire)
  localparam int BTN_A     = 31;
  localparam int BTN_B     = 30;
  localparam int BTN_Z     = 29;
  localparam int BTN_START = 28;
  localparam int BTN_DU    = 27;
  localparam int BTN_DD    = 26;
  localparam int BTN_DL    = 25;
  localparam int BTN_DR    = 24;
  localparam int BTN_L     = 21;
  localparam int BTN_R     = 20;
  localparam int BTN_CU    = 19;
  localparam int BTN_CD    = 18;
  localparam int BTN_CL    = 17;
  localparam int BTN_CR    = 16;

  localparam int AXIS_X_MSB = 15;
  localparam int AXIS_X_LSB = 8;
  localparam int AXIS_Y_MSB = 7;
  localparam int AXIS_Y_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_FALL = 3'd1,
    ST_MEASURE   = 3'd2,
    ST_WAIT_RISE = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5,
    ST_HOLD      = 3'd6
  } rx_state_t;

  function automatic logic signed [7:0] axis_x(input logic [31:0] word);
    return word[AXIS_X_MSB:AXIS_X_LSB];
  endfunction

  function automatic logic signed [7:0] axis_y(input logic [31:0] word);
    return word[AXIS_Y_MSB:AXIS_Y_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/n64_response_receiver_line_sync.sv
// n64_line_sync: two-flop synchroniser for the open-drain data line plus fall/rise pulses.
`default_nettype none
`timescale 1ns/1ps

module n64_line_sync (
  input  logic clk,
  input  logic Reset,
  input  logic data_in,
  output logic line,
  output logic fall,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Line idles high, so every stage resets to 1 to avoid a false edge after reset
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= data_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign line = r_sync;
  assign fall = r_prev & ~r_sync;
  assign rise = ~r_prev & r_sync;

endmodule

`default_nettype wire

// File: rtl/n64_response_receiver.sv
// n64_response_receiver: pulse-width decoder for the 32-bit N64 controller response and stop bit.
`default_nettype none
`timescale 1ns/1ps

module n64_response_receiver
  import n64_pkg::*;
#(
  parameter int CYCLES_PER_US  = 12,
  parameter int SAMPLE_CYCLES  = 2 * CYCLES_PER_US,
  parameter int GLITCH_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 8 * CYCLES_PER_US
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Enable_Recieve,
  input  logic        Data_In,
  output logic [31:0] Buttons,
  output logic        Data_Valid,
  output logic        Frame_Error,
  output logic        Busy
);

  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_SAMPLE  = c_CNT_W'(SAMPLE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_GLITCH  = c_CNT_W'(GLITCH_CYCLES);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);
  localparam logic [5:0] c_STOP_IDX = 6'(RESP_BITS);
  localparam logic [5:0] c_DONE_IDX = 6'(RESP_BITS + 1);

  logic w_line, w_fall, w_rise;

  n64_line_sync u_line_sync (
    .clk     (clk),
    .Reset   (Reset),
    .data_in (Data_In),
    .line    (w_line),
    .fall    (w_fall),
    .rise    (w_rise)
  );

  rx_state_t          r_state,    w_state_next;
  logic [c_CNT_W-1:0] r_wait_cnt, w_wait_cnt_next;
  logic [c_CNT_W-1:0] r_low_cnt,  w_low_cnt_next;
  logic [5:0]         r_bit_cnt,  w_bit_cnt_next;
  logic [31:0]        r_shift,    w_shift_next;
  logic [31:0]        r_buttons,  w_buttons_next;
  rx_state_t          w_abort_state;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_low_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_buttons  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_low_cnt  <= w_low_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_buttons  <= w_buttons_next;
    end
  end

  // Two timers: r_wait_cnt bounds the gap between bits and survives a rejected
  // glitch, r_low_cnt times one bit from its falling edge.
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_low_cnt_next  = r_low_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_buttons_next  = r_buttons;
    w_abort_state   = (r_bit_cnt != '0) ? ST_ERROR : ST_IDLE;

    case (r_state)
      ST_IDLE: begin
        w_bit_cnt_next = '0;
        if (Enable_Recieve) begin
          w_wait_cnt_next = '0;
          w_state_next    = ST_WAIT_FALL;
        end
      end
      ST_WAIT_FALL: begin
        if (!Enable_Recieve) begin
          w_state_next = w_abort_state;
        end else if (w_fall) begin
          w_low_cnt_next = '0;
          w_state_next   = ST_MEASURE;
        end else if (r_wait_cnt == c_TIMEOUT) begin
          w_state_next = ST_ERROR;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!Enable_Recieve) begin
          w_state_next = w_abort_state;
        end else if (w_rise && (r_low_cnt <= c_GLITCH)) begin
          w_state_next = ST_WAIT_FALL;
        end else if (r_low_cnt == c_SAMPLE) begin
          if (r_bit_cnt < c_STOP_IDX) begin
            w_shift_next   = {r_shift[30:0], w_line};
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end else begin
            w_bit_cnt_next = c_DONE_IDX;
          end
          w_low_cnt_next = r_low_cnt + 1'b1;
          w_state_next   = ST_WAIT_RISE;
        end else begin
          w_low_cnt_next = r_low_cnt + 1'b1;
        end
      end
      ST_WAIT_RISE: begin
        if (!Enable_Recieve) begin
          w_state_next = w_abort_state;
        end else if (w_line) begin
          if (r_bit_cnt == c_DONE_IDX) begin
            w_buttons_next = r_shift;
            w_state_next   = ST_DONE;
          end else begin
            w_wait_cnt_next = '0;
            w_state_next    = ST_WAIT_FALL;
          end
        end else if (r_low_cnt >= c_TIMEOUT) begin
          w_state_next = ST_ERROR;
        end else begin
          w_low_cnt_next = r_low_cnt + 1'b1;
        end
      end
      ST_DONE:  w_state_next = ST_HOLD;
      // An aborted window lands here with enable already low and returns straight to IDLE
      ST_ERROR: w_state_next = Enable_Recieve ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        if (!Enable_Recieve) begin
          w_state_next = ST_IDLE;
        end
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  assign Buttons     = r_buttons;
  assign Data_Valid  = (r_state == ST_DONE);
  assign Frame_Error = (r_state == ST_ERROR);
  assign Busy        = (r_state == ST_MEASURE) || (r_state == ST_WAIT_RISE) ||
                       ((r_state == ST_WAIT_FALL) && (r_bit_cnt != '0));

endmodule

`default_nettype wire

// File: tb/tb_n64_response_receiver.sv
// tb_n64_response_receiver: directed frames with a queue-based scoreboard and pulse monitor.
`default_nettype none
`timescale 1ns/1ps

module tb_n64_response_receiver;
  import n64_pkg::*;

  localparam int CPU     = 12;
  localparam int TIMEOUT = 8 * CPU;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Enable_Recieve = 1'b0;
  logic        Data_In = 1'b1;
  logic [31:0] Buttons;
  logic        Data_Valid;
  logic        Frame_Error;
  logic        Busy;

  n64_response_receiver #(
    .CYCLES_PER_US  (CPU),
    .SAMPLE_CYCLES  (2 * CPU),
    .GLITCH_CYCLES  (2),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk            (clk),
    .Reset          (Reset),
    .Enable_Recieve (Enable_Recieve),
    .Data_In        (Data_In),
    .Buttons        (Buttons),
    .Data_Valid     (Data_Valid),
    .Frame_Error    (Frame_Error),
    .Busy           (Busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [31:0] word;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_good = 32'h0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every result pulse must match the oldest expected result
  always @(negedge clk) begin
    exp_t e;
    if (Data_Valid || Frame_Error) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual valid=%0b err=%0b required no pulse",
                 Data_Valid, Frame_Error);
      end else begin
        e = sb_q.pop_front();
        check32("pulse_kind", {30'd0, Data_Valid, Frame_Error}, {30'd0, ~e.is_err, e.is_err});
        check32("buttons", Buttons, e.word);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic v, input int n);
    Data_In = v;
    cycles(n);
  endtask

  task automatic send_bit(input logic b);
    if (b) begin
      drive(1'b0, CPU);
      drive(1'b1, 3 * CPU);
    end else begin
      drive(1'b0, 3 * CPU);
      drive(1'b1, CPU);
    end
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits);
    for (int i = 31; i >= 32 - nbits; i--) send_bit(w[i]);
  endtask

  task automatic send_stop();
    drive(1'b0, CPU);
    drive(1'b1, 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      cycles(1);
      n++;
    end
    check32(name, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic full_frame(input string name, input logic [31:0] w, input logic glitch);
    Enable_Recieve = 1'b1;
    sb_q.push_back('{is_err: 1'b0, word: w});
    cycles(5);
    if (glitch) begin
      drive(1'b0, 1);
      drive(1'b1, 10);
    end
    send_bits(w, 32);
    send_stop();
    drain(name);
    Enable_Recieve = 1'b0;
    cycles(5);
    last_good = w;
  endtask

  task automatic check_idle_outputs(input string name);
    check32({name, "_buttons"}, Buttons, 32'h0);
    check32({name, "_flags"}, {29'd0, Data_Valid, Frame_Error, Busy}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;

    // Reset state, then a quiet idle period
    cycles(3);
    check_idle_outputs("reset");
    Reset = 1'b1;
    cycles(100);
    check_idle_outputs("idle");

    full_frame("frame_80000000", 32'h8000_0000, 1'b0);
    check32("buttons_a_set", {31'd0, Buttons[BTN_A]}, 32'd1);

    full_frame("frame_00007f81", 32'h0000_7F81, 1'b0);
    check32("axis_x", 32'(Buttons[15:8]), 32'h7F);
    check32("axis_y_signed", 32'($signed(Buttons[7:0])), 32'hFFFF_FF81);

    // No controller: the line never falls
    Enable_Recieve = 1'b1;
    sb_q.push_back('{is_err: 1'b1, word: last_good});
    lat = 0;
    while (!Frame_Error && lat < TIMEOUT + 10) begin
      cycles(1);
      lat++;
    end
    checks++;
    if (lat < TIMEOUT + 1 || lat > TIMEOUT + 2) begin
      failures++;
      $display("FAIL timeout_latency actual=%0d required=%0d..%0d", lat, TIMEOUT + 1, TIMEOUT + 2);
    end
    cycles(60);
    drain("timeout_drain");
    Enable_Recieve = 1'b0;
    cycles(5);

    full_frame("frame_glitch_ffff0000", 32'hFFFF_0000, 1'b1);

    // Window closes after 10 bits
    Enable_Recieve = 1'b1;
    sb_q.push_back('{is_err: 1'b1, word: last_good});
    cycles(5);
    send_bits(32'hA5A5_A5A5, 10);
    Enable_Recieve = 1'b0;
    drain("abort_drain");
    cycles(5);
    check32("abort_buttons_kept", Buttons, 32'hFFFF_0000);

    // Reset in the middle of a frame
    Enable_Recieve = 1'b1;
    cycles(5);
    send_bits(32'h1234_5678, 5);
    drive(1'b0, 5);
    Reset = 1'b0;
    #1;
    check_idle_outputs("midframe_reset");
    Enable_Recieve = 1'b0;
    Data_In = 1'b1;
    cycles(3);
    Reset = 1'b1;
    cycles(5);
    last_good = 32'h0;
    full_frame("frame_after_reset", 32'h1234_5678, 1'b0);

    cycles(20);
    check32("queue_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/n64_response_receiver.md
Name: n64_response_receiver

Overview:
Downstream stage of the N64 poll sequencer. While the sequencer holds Enable_Recieve high, this block samples the controller's open-drain data line. It decodes the 32-bit controller response plus the stop bit, using pulse-width timing. It presents the decoded word as a registered button/axis status with a one-cycle valid strobe, and flags malformed or missing responses.

Parameters:
CYCLES_PER_US, 12, clk cycles per microsecond; all timing derives from it.
SAMPLE_CYCLES, 2*CYCLES_PER_US, cycles after a bit's falling edge at which the line is sampled.
GLITCH_CYCLES, 2, a low pulse of this many cycles or fewer is rejected as noise.
TIMEOUT_CYCLES, 8*CYCLES_PER_US, maximum wait for a falling edge, and maximum continuous low time.

Ports:
clk  input  1  system clock
Reset  input  1  asynchronous, active-low reset
Enable_Recieve  input  1  receive window from the poll sequencer; level-sensitive
Data_In  input  1  raw N64 data line, asynchronous to clk
Buttons  output  32  last good response word, MSB = first bit received
Data_Valid  output  1  one-cycle pulse when Buttons is updated
Frame_Error  output  1  one-cycle pulse on timeout, glitch-only frame, or aborted frame
Busy  output  1  high from the first qualified falling edge until frame end or abort

Behaviour:
- Reset values: Buttons=0, Data_Valid=0, Frame_Error=0, Busy=0, FSM=IDLE, synchroniser flops=1 (line idles high).
- Synchronisation and edge detection:
  - Data_In passes through a 2-flop synchroniser, then a 1-flop edge detector.
  - A falling edge is seen 3 clk cycles after the pin transition.
- IDLE:
  - Clears the bit counter (6-bit, 0..33).
  - Moves to WAIT_FALL when Enable_Recieve=1.
- WAIT_FALL:
  - On a falling edge, clears the cycle counter and moves to MEASURE.
  - If the counter reaches TIMEOUT_CYCLES, moves to ERROR. This applies to the first bit too: no controller means timeout.
- MEASURE:
  - Counts cycles while the line is low.
  - If the line rises with count ≤ GLITCH_CYCLES, the pulse is discarded and the FSM returns to WAIT_FALL. The bit counter is unchanged and the timeout counter is not reset.
  - At count == SAMPLE_CYCLES, samples the synced line:
    - If bit counter < 32: shifts the sampled value in (shift left, new bit into LSB), increments the bit counter, moves to WAIT_RISE.
    - If bit counter == 32 (stop bit): moves to WAIT_RISE. The sampled value is ignored.
  - Low for TIMEOUT_CYCLES moves to ERROR.
- WAIT_RISE:
  - Waits for the line high.
  - Low held for TIMEOUT_CYCLES total since the falling edge moves to ERROR.
  - On high: if the stop bit is done, moves to DONE; otherwise clears the cycle counter and moves to WAIT_FALL.
- DONE (1 cycle):
  - Buttons <= shift register; Data_Valid=1.
  - Then moves to HOLD.
- ERROR (1 cycle):
  - Frame_Error=1; Buttons unchanged.
  - Then moves to HOLD.
- HOLD:
  - Stays until Enable_Recieve=0, then moves to IDLE.
  - Guarantees exactly one result, either Valid or Error, per receive window.
- Enable_Recieve falls while in WAIT_FALL/MEASURE/WAIT_RISE:
  - If bit counter > 0, pulses Frame_Error in the next cycle, then goes to IDLE.
  - If bit counter == 0, goes to IDLE silently. This covers a window closed with no response.
- Busy=1 in MEASURE, WAIT_RISE, and in WAIT_FALL when bit counter > 0.
- Data_Valid and Frame_Error are never high in the same cycle.
- Reset asserted mid-frame returns to the reset values immediately; the partial word is lost.
- Cycle counter width is $clog2(TIMEOUT_CYCLES+1) and saturates at TIMEOUT_CYCLES.

Decomposition:
- Package n64_pkg holds:
  - Buttons bit index constants: A=31, B=30, Z=29, START=28, DU=27, DD=26, DL=25, DR=24, L=21, R=20, CU=19, CD=18, CL=17, CR=16.
  - Axis field ranges: X=15:8 and Y=7:0, both signed 8-bit.
  - The FSM state enum.
  - RESP_BITS=32.
- Natural sub-module: n64_line_sync, containing the 2-flop synchroniser plus the fall/rise edge pulses.

Test Plan:
1. Reset low, then high with Data_In=1 and Enable_Recieve=0 → all outputs 0, FSM IDLE; no pulses for 100 cycles.
2. Enable_Recieve=1, drive response 0x8000_0000 plus stop bit, with 0=3us low/1us high, 1=1us low/3us high, stop=1us low → Buttons=0x8000_0000 and one Data_Valid pulse after the stop rise (3-cycle sync latency), Frame_Error=0.
3. Drive response 0x0000_7F81 → Buttons[15:8]=0x7F and Buttons[7:0]=0x81 (Y=-127); one Data_Valid.
4. Enable_Recieve=1, Data_In held high for TIMEOUT_CYCLES+5 → one Frame_Error pulse at TIMEOUT_CYCLES+1; Buttons keeps its prior value 0x0000_7F81; no further pulses until Enable_Recieve toggles.
5. Insert a 1-cycle low glitch before bit 0, then send a valid frame 0xFFFF_0000 → glitch ignored, Buttons=0xFFFF_0000.
6. Deassert Enable_Recieve after 10 bits → one Frame_Error, Buttons unchanged. Separately, assert Reset mid-frame → all outputs 0 immediately; the next full frame decodes correctly.
